noc_switch_alloc: RTL and testbench
===================================

Name: noc_switch_alloc

Overview:
- Per-router switch allocator for the 5-port mesh router (north, south, east, west, local).
- Sits directly upstream of the router crossbar.
- Takes head-flit requests from the five input queues and runs an independent round-robin arbitration per output port.
- Drives the crossbar's per-output grant and select lines, and the per-input queue pop strobes, all registered.

Parameters:
- RR_INIT, 0: initial round-robin pointer value for every output after reset (0..4).
- ALLOW_UTURN, 0: when 1, an input may request its own direction; when 0, such requests are ignored. Local-to-local is always allowed.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset; asynchronous, active-high
- req_{n,s,e,w,l}_i  input  1 each  input queue X is non-empty and its head flit requests an output
- dest_{n,s,e,w,l}_i  input  3 each  requested output for input X's head flit; encoding 0=N, 1=S, 2=E, 3=W, 4=L
- out_ready_{n,s,e,w,l}_i  input  1 each  downstream of output X can accept a flit this cycle
- grant_access_{north,south,east,west,local}_o  output  1 each  crossbar output X drives a flit this cycle
- address_route_{n,s,e,w,l}_o  output  3 each  input index (same encoding as dest) selected onto output X; 0 when not granted
- pop_{north,south,east,west,local}q_o  output  1 each  dequeue input queue X this cycle; its head flit is on the crossbar

Behaviour:
- Reset (async assert):
  - All outputs 0 immediately.
  - All five RR pointers = RR_INIT.
  - Deassertion takes effect at the next clk_i edge.
- Latency: arbitration is combinational on cycle-t inputs. Grant, route and pop are registered and appear in cycle t+1.
- Eligibility: input i is eligible for output j in cycle t when all of the following hold:
  - req_i = 1.
  - dest_i = j.
  - dest_i <= 4.
  - pop_i_o = 0 in cycle t. An input popped this cycle is masked because its head is changing.
  - U-turn rule satisfied: with ALLOW_UTURN = 0, dest_i equal to i's own direction (i in 0..3) is ineligible.
- Arbitration for output j:
  - Runs only if out_ready_j_i = 1.
  - Winner is the first eligible input scanning ptr_j, ptr_j+1, ... modulo 5.
  - If no input is eligible, or out_ready is 0: grant_j = 0, route_j = 0, ptr_j unchanged.
- On a win by input w for output j (at the clock edge):
  - grant_access_j_o <= 1, address_route_j_o <= w, pop_w_o <= 1.
  - ptr_j <= (w+1) mod 5.
- Each input has exactly one dest, so at most one output can grant a given input. Pop is therefore one-hot per input; no conflicts across outputs.
- Up to five grants are allowed per cycle, one per output.
- dest values 5..7: request ignored and never granted. No error output.
- A given input can win at most every other cycle because of the pop mask. A sustained single requester therefore gets 50% throughput. This is the intended, documented limitation.
- out_ready dropping in the cycle a grant is registered does not revoke that grant. The readiness sampled in cycle t governs the grant issued in cycle t+1.
- Mid-operation reset clears pending grants and pops asynchronously. A flit whose grant is cleared this way is not dequeued.
- Pointers are 3-bit registers and are always kept in 0..4.

Test Plan:
- Reset checks:
  - Assert rst_i mid-cycle while grants are active -> all grant/route/pop outputs go to 0 before the next edge.
  - After release, first grants follow RR_INIT = 0 ordering.
- Single request: req_l=1, dest_l=0 (N), out_ready_n=1 at cycle 0 -> cycle 1: grant_access_north_o=1, address_route_n_o=4, pop_localq_o=1; cycle 2: all 0 (pop mask) even though req_l is still 1.
- Contention: N, S, E, W all request L with out_ready_l=1 held, ptr_l=0, requests re-asserted after each pop -> address_route_l_o sequence N(0), S(1), E(2), W(3), N(0), ... Each input receives exactly one grant per four grants.
- Parallel grants: N->E, S->W, E->L, W->N, L->S in one cycle, all ready -> next cycle all five grants=1, routes E=0, W=1, L=2, N=3, S=4, all five pops=1.
- Back-pressure:
  - req_n=1, dest_n=3 (W), out_ready_w=0 for 3 cycles -> no grant, no pop, ptr_w unchanged.
  - Raise ready -> grant one cycle later with route 0.
- Illegal and U-turn requests:
  - dest_e=6 -> never granted.
  - With ALLOW_UTURN=0, req_e with dest_e=2 -> never granted.
  - req_l with dest_l=4 -> granted, route_l=4.

Source files
------------

// File: rtl/noc_switch_alloc.sv
// noc_switch_alloc
//   Switch allocator for a 5-port mesh router (N=0, S=1, E=2, W=3, L=4).
//   Each output runs its own round-robin arbitration over the head-flit
//   requests of the five input queues. Grant, route select and queue pop
//   strobes are registered, so they appear one cycle after the request.
// Ports
//   clk_i, rst_i                     clock, async active-high reset
//   req_X_i, dest_X_i[2:0]           head-flit request and target output of input X
//   out_ready_X_i                    downstream of output X can take a flit
//   grant_access_<dir>_o             output crossbar lane drives a flit
//   address_route_X_o[2:0]           input index switched onto output X (0 if idle)
//   pop_<dir>q_o                     dequeue input queue X
module noc_switch_alloc #(
  parameter int RR_INIT     = 0,
  parameter bit ALLOW_UTURN = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_n_i,
  input  logic       req_s_i,
  input  logic       req_e_i,
  input  logic       req_w_i,
  input  logic       req_l_i,
  input  logic [2:0] dest_n_i,
  input  logic [2:0] dest_s_i,
  input  logic [2:0] dest_e_i,
  input  logic [2:0] dest_w_i,
  input  logic [2:0] dest_l_i,
  input  logic       out_ready_n_i,
  input  logic       out_ready_s_i,
  input  logic       out_ready_e_i,
  input  logic       out_ready_w_i,
  input  logic       out_ready_l_i,
  output logic       grant_access_north_o,
  output logic       grant_access_south_o,
  output logic       grant_access_east_o,
  output logic       grant_access_west_o,
  output logic       grant_access_local_o,
  output logic [2:0] address_route_n_o,
  output logic [2:0] address_route_s_o,
  output logic [2:0] address_route_e_o,
  output logic [2:0] address_route_w_o,
  output logic [2:0] address_route_l_o,
  output logic       pop_northq_o,
  output logic       pop_southq_o,
  output logic       pop_eastq_o,
  output logic       pop_westq_o,
  output logic       pop_localq_o
);

  logic [4:0] w_req;
  logic [4:0] w_ready;
  logic [2:0] w_dest [5];

  logic [4:0] r_grant;
  logic [4:0] r_pop;
  logic [2:0] r_route [5];
  logic [2:0] r_ptr [5];

  logic [4:0] w_elig [5];      // w_elig[out][in]
  logic [4:0] w_win_vld;
  logic [2:0] w_win_idx [5];
  logic [4:0] w_pop_nxt;

  assign w_req   = {req_l_i, req_w_i, req_e_i, req_s_i, req_n_i};
  assign w_ready = {out_ready_l_i, out_ready_w_i, out_ready_e_i, out_ready_s_i, out_ready_n_i};
  assign w_dest[0] = dest_n_i;
  assign w_dest[1] = dest_s_i;
  assign w_dest[2] = dest_e_i;
  assign w_dest[3] = dest_w_i;
  assign w_dest[4] = dest_l_i;

  // dest == j with j in 0..4 already excludes the illegal codes 5..7.
  // An input popped this cycle is masked because its head flit is changing.
  always_comb begin
    for (int j = 0; j < 5; j++) begin
      w_elig[j] = '0;
      for (int i = 0; i < 5; i++) begin
        w_elig[j][i] = w_req[i] && (w_dest[i] == 3'(j)) && !r_pop[i] &&
                       (ALLOW_UTURN || (i == 4) || (i != j));
      end
    end
  end

  // Scan ptr, ptr+1, ... mod 5; the first eligible input wins.
  always_comb begin
    logic [3:0] v_sum;
    logic [2:0] v_cand;
    v_sum  = '0;
    v_cand = '0;
    for (int j = 0; j < 5; j++) begin
      w_win_vld[j] = 1'b0;
      w_win_idx[j] = '0;
      if (w_ready[j]) begin
        for (int k = 0; k < 5; k++) begin
          v_sum  = {1'b0, r_ptr[j]} + 4'(k);
          v_cand = (v_sum >= 4'd5) ? 3'(v_sum - 4'd5) : v_sum[2:0];
          if (!w_win_vld[j] && w_elig[j][v_cand]) begin
            w_win_vld[j] = 1'b1;
            w_win_idx[j] = v_cand;
          end
        end
      end
    end
  end

  // Each input has one dest, so at most one output can select it.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_pop_nxt[i] = 1'b0;
      for (int j = 0; j < 5; j++) begin
        if (w_win_vld[j] && (w_win_idx[j] == 3'(i))) w_pop_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_grant <= '0;
      r_pop   <= '0;
      for (int j = 0; j < 5; j++) begin
        r_route[j] <= '0;
        r_ptr[j]   <= 3'(RR_INIT);
      end
    end else begin
      r_grant <= w_win_vld;
      r_pop   <= w_pop_nxt;
      for (int j = 0; j < 5; j++) begin
        r_route[j] <= w_win_vld[j] ? w_win_idx[j] : 3'd0;
        if (w_win_vld[j]) r_ptr[j] <= (w_win_idx[j] == 3'd4) ? 3'd0 : w_win_idx[j] + 3'd1;
      end
    end
  end

  assign grant_access_north_o = r_grant[0];
  assign grant_access_south_o = r_grant[1];
  assign grant_access_east_o  = r_grant[2];
  assign grant_access_west_o  = r_grant[3];
  assign grant_access_local_o = r_grant[4];
  assign address_route_n_o    = r_route[0];
  assign address_route_s_o    = r_route[1];
  assign address_route_e_o    = r_route[2];
  assign address_route_w_o    = r_route[3];
  assign address_route_l_o    = r_route[4];
  assign pop_northq_o         = r_pop[0];
  assign pop_southq_o         = r_pop[1];
  assign pop_eastq_o          = r_pop[2];
  assign pop_westq_o          = r_pop[3];
  assign pop_localq_o         = r_pop[4];

endmodule

// File: tb/tb_noc_switch_alloc.sv
// Directed testbench for noc_switch_alloc (RR_INIT=0, ALLOW_UTURN=0).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_noc_switch_alloc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] req = '0;
  logic [4:0] rdy = '0;
  logic [2:0] dest [5];

  logic [4:0]  grant;
  logic [4:0]  pop;
  logic [2:0]  rt_n, rt_s, rt_e, rt_w, rt_l;
  logic [14:0] route;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign route = {rt_l, rt_w, rt_e, rt_s, rt_n};

  noc_switch_alloc dut (
    .clk_i(clk), .rst_i(rst),
    .req_n_i(req[0]), .req_s_i(req[1]), .req_e_i(req[2]), .req_w_i(req[3]), .req_l_i(req[4]),
    .dest_n_i(dest[0]), .dest_s_i(dest[1]), .dest_e_i(dest[2]), .dest_w_i(dest[3]), .dest_l_i(dest[4]),
    .out_ready_n_i(rdy[0]), .out_ready_s_i(rdy[1]), .out_ready_e_i(rdy[2]),
    .out_ready_w_i(rdy[3]), .out_ready_l_i(rdy[4]),
    .grant_access_north_o(grant[0]), .grant_access_south_o(grant[1]),
    .grant_access_east_o(grant[2]), .grant_access_west_o(grant[3]),
    .grant_access_local_o(grant[4]),
    .address_route_n_o(rt_n), .address_route_s_o(rt_s), .address_route_e_o(rt_e),
    .address_route_w_o(rt_w), .address_route_l_o(rt_l),
    .pop_northq_o(pop[0]), .pop_southq_o(pop[1]), .pop_eastq_o(pop[2]),
    .pop_westq_o(pop[3]), .pop_localq_o(pop[4])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req = '0;
    rdy = '0;
    for (int i = 0; i < 5; i++) dest[i] = 3'd0;
    step();
    step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) dest[i] = 3'd0;
    rst = 1'b1;
    #12;
    n_cmp++;
    if ({grant, pop, route} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want 0", {grant, pop, route});
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    req[4] = 1'b1; dest[4] = 3'd0; rdy[0] = 1'b1;
    step();
    n_cmp++;
    if (grant !== 5'b00001 || pop !== 5'b10000 || route !== {12'd0, 3'd4}) begin
      n_bad++;
      $display("FAIL single_grant: grant=%b pop=%b route=%h want 00001 10000 0004", grant, pop, route);
    end
    step();
    n_cmp++;
    if ({grant, pop, route} !== 25'd0) begin
      n_bad++;
      $display("FAIL single_popmask: got %h want 0", {grant, pop, route});
    end
    step();
    n_cmp++;
    if (grant !== 5'b00001 || route !== {12'd0, 3'd4}) begin
      n_bad++;
      $display("FAIL single_regrant: grant=%b route=%h want 00001 0004", grant, route);
    end
    idle();   // ptr_n = 0
  endtask

  task automatic test_contention();
    logic [2:0] exp_seq [8];
    exp_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2, 3'd3};
    req = 5'b01111; rdy[4] = 1'b1;
    for (int i = 0; i < 4; i++) dest[i] = 3'd4;
    for (int n = 0; n < 8; n++) begin
      step();
      n_cmp++;
      if (grant !== 5'b10000 || rt_l !== exp_seq[n] || pop !== (5'b00001 << exp_seq[n])) begin
        n_bad++;
        $display("FAIL contention_%0d: grant=%b route_l=%0d pop=%b want route_l=%0d", n, grant, rt_l, pop, exp_seq[n]);
      end
    end
    idle();   // ptr_l = 4
  endtask

  task automatic test_parallel();
    req = 5'b11111; rdy = 5'b11111;
    dest[0] = 3'd2; dest[1] = 3'd3; dest[2] = 3'd4; dest[3] = 3'd0; dest[4] = 3'd1;
    step();
    n_cmp++;
    if (grant !== 5'b11111 || pop !== 5'b11111 ||
        route !== {3'd2, 3'd1, 3'd0, 3'd4, 3'd3}) begin
      n_bad++;
      $display("FAIL parallel: grant=%b pop=%b route=%h", grant, pop, route);
    end
    idle();   // ptr: n=4 s=0 e=1 w=2 l=3
  endtask

  task automatic test_backpressure();
    req[0] = 1'b1; dest[0] = 3'd3; rdy = 5'b10111;
    for (int n = 0; n < 3; n++) begin
      step();
      n_cmp++;
      if (grant !== 5'd0 || pop !== 5'd0) begin
        n_bad++;
        $display("FAIL backpressure_%0d: grant=%b pop=%b want 0 0", n, grant, pop);
      end
    end
    rdy[3] = 1'b1;
    step();
    n_cmp++;
    if (grant !== 5'b01000 || rt_w !== 3'd0 || pop !== 5'b00001) begin
      n_bad++;
      $display("FAIL backpressure_release: grant=%b route_w=%0d pop=%b want 01000 0 00001", grant, rt_w, pop);
    end
    idle();
  endtask

  task automatic test_illegal_uturn();
    req[2] = 1'b1; dest[2] = 3'd6; rdy = 5'b11111;
    for (int n = 0; n < 3; n++) begin
      step();
      n_cmp++;
      if (grant !== 5'd0 || pop !== 5'd0) begin
        n_bad++;
        $display("FAIL illegal_dest_%0d: grant=%b pop=%b want 0 0", n, grant, pop);
      end
    end
    dest[2] = 3'd2;
    for (int n = 0; n < 3; n++) begin
      step();
      n_cmp++;
      if (grant !== 5'd0 || pop !== 5'd0) begin
        n_bad++;
        $display("FAIL uturn_east_%0d: grant=%b pop=%b want 0 0", n, grant, pop);
      end
    end
    req = 5'b10000; dest[4] = 3'd4;
    step();
    n_cmp++;
    if (grant !== 5'b10000 || rt_l !== 3'd4 || pop !== 5'b10000) begin
      n_bad++;
      $display("FAIL local_to_local: grant=%b route_l=%0d pop=%b want 10000 4 10000", grant, rt_l, pop);
    end
    idle();
  endtask

  task automatic test_mid_reset();
    req = 5'b11111; rdy = 5'b11111;
    dest[0] = 3'd2; dest[1] = 3'd3; dest[2] = 3'd4; dest[3] = 3'd0; dest[4] = 3'd1;
    step();
    n_cmp++;
    if (grant !== 5'b11111) begin
      n_bad++;
      $display("FAIL midreset_pre: grant=%b want 11111", grant);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({grant, pop, route} !== 25'd0) begin
      n_bad++;
      $display("FAIL midreset_clear: got %h want 0", {grant, pop, route});
    end
    req = 5'b00000; rdy = 5'b00000;
    #1;
    rst = 1'b0;
    // ptr_n was 4 before reset; back at RR_INIT=0 S wins before L.
    req = 5'b10110; rdy[0] = 1'b1;
    dest[1] = 3'd0; dest[2] = 3'd0; dest[4] = 3'd0;
    step();
    n_cmp++;
    if (grant !== 5'b00001 || rt_n !== 3'd1 || pop !== 5'b00010) begin
      n_bad++;
      $display("FAIL rrinit_first: grant=%b route_n=%0d pop=%b want 00001 1 00010", grant, rt_n, pop);
    end
    step();
    n_cmp++;
    if (grant !== 5'b00001 || rt_n !== 3'd2 || pop !== 5'b00100) begin
      n_bad++;
      $display("FAIL rrinit_second: grant=%b route_n=%0d pop=%b want 00001 2 00100", grant, rt_n, pop);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_parallel();
    test_backpressure();
    test_illegal_uturn();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
